// File: rtl/uart_fifo_controller.sv
// Buffered 8N1 UART behind a single 32-bit CSR: independent TX/RX FIFOs,
// synchronised mid-bit RX sampling with false-start rejection, sticky error flags.
module uart_fifo_controller #(
    parameter int unsigned FREQ_DIV = 868,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd,
    output logic                      txd,
    input  logic                      csr_we,
    input  logic [31:0]               csr_wdata,
    input  logic                      csr_re,
    output logic [31:0]               csr_rdata,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    output logic [$clog2(RX_DEPTH):0] rx_level
);
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_LW = TX_AW + 1;
    localparam int unsigned RX_LW = RX_AW + 1;
    localparam int unsigned CNT_W = $clog2(FREQ_DIV + 1);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FREQ_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(FREQ_DIV);
    localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(FREQ_DIV / 2);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // CSR decode
    logic ctrl_wr_c;
    logic data_wr_c;
    logic unused_wdata;

    assign ctrl_wr_c    = csr_we & csr_wdata[31];
    assign data_wr_c    = csr_we & ~csr_wdata[31];
    assign unused_wdata = ^csr_wdata[30:8];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wptr;
    logic [TX_AW-1:0] tx_rptr;
    logic             tx_full_c;
    logic             tx_empty_c;
    logic             tx_push_c;
    logic             tx_pop_c;

    assign tx_full_c  = (tx_level == TX_LW'(TX_DEPTH));
    assign tx_empty_c = (tx_level == '0);
    assign tx_push_c  = data_wr_c & (~tx_full_c | tx_pop_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push_c) tx_wptr <= tx_wptr + TX_AW'(1);
            if (tx_pop_c)  tx_rptr <= tx_rptr + TX_AW'(1);
            case ({tx_push_c, tx_pop_c})
                2'b10:   tx_level <= tx_level + TX_LW'(1);
                2'b01:   tx_level <= tx_level - TX_LW'(1);
                default: tx_level <= tx_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push_c) tx_mem[tx_wptr] <= csr_wdata[7:0];
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t        tx_state;
    tx_state_t        tx_state_d;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] tx_cnt_d;
    logic [2:0]       tx_bit;
    logic [2:0]       tx_bit_d;
    logic [7:0]       tx_shift;
    logic [7:0]       tx_shift_d;
    logic             txd_d;
    logic             tx_start_c;
    logic             tx_last_c;

    assign tx_last_c = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            txd      <= txd_d;
        end
    end

    // STOP completing with data waiting reloads directly, so frames are back-to-back
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        txd_d      = txd;
        tx_start_c = 1'b0;
        tx_pop_c   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (!tx_empty_c) tx_start_c = 1'b1;
            end
            TX_START: begin
                if (tx_last_c) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift[0];
                end else begin
                    tx_cnt_d = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_last_c) begin
                    tx_cnt_d = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit + 3'd1;
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        txd_d      = tx_shift[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_last_c) begin
                    tx_cnt_d = '0;
                    if (!tx_empty_c) begin
                        tx_start_c = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt + CNT_W'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
            end
        endcase
        if (tx_start_c) begin
            tx_pop_c   = 1'b1;
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = tx_mem[tx_rptr];
            txd_d      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser and FSM
    // ------------------------------------------------------------------
    logic [1:0]       rx_sync;
    logic             rxs;
    rx_state_t        rx_state;
    rx_state_t        rx_state_d;
    logic [CNT_W-1:0] rx_cnt;
    logic [CNT_W-1:0] rx_cnt_d;
    logic [2:0]       rx_bit;
    logic [2:0]       rx_bit_d;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_shift_d;
    logic             rx_stop_c;
    logic             rx_tick_c;

    assign rxs       = rx_sync[1];
    assign rx_tick_c = (rx_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
        end
    end

    // Counter counts down; a sample is taken on the edge where it reads 1
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_stop_c  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = BIT_HALF;
                end
            end
            RX_START: begin
                if (rx_tick_c) begin
                    if (rxs) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_FULL;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_tick_c) begin
                    rx_shift_d = {rxs, rx_shift[7:1]};
                    rx_cnt_d   = BIT_FULL;
                    if (rx_bit == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_tick_c) begin
                    rx_stop_c  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt - CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO and sticky flags; a control write beats any same-cycle event
    // ------------------------------------------------------------------
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wptr;
    logic [RX_AW-1:0] rx_rptr;
    logic             rx_full_c;
    logic             rx_empty_c;
    logic             rx_push_c;
    logic             rx_pop_c;
    logic             ovr_set_c;
    logic             ferr_set_c;
    logic             overrun;
    logic             frame_err;
    logic [7:0]       rx_head_c;

    assign rx_full_c  = (rx_level == RX_LW'(RX_DEPTH));
    assign rx_empty_c = (rx_level == '0);
    assign rx_pop_c   = csr_re & ~rx_empty_c & ~ctrl_wr_c;
    assign rx_push_c  = rx_stop_c & rxs & (~rx_full_c | rx_pop_c) & ~ctrl_wr_c;
    assign ovr_set_c  = rx_stop_c & rxs & rx_full_c & ~rx_pop_c;
    assign ferr_set_c = rx_stop_c & ~rxs;

    always_ff @(posedge clk) begin
        if (rst || ctrl_wr_c) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_level <= '0;
        end else begin
            if (rx_push_c) rx_wptr <= rx_wptr + RX_AW'(1);
            if (rx_pop_c)  rx_rptr <= rx_rptr + RX_AW'(1);
            case ({rx_push_c, rx_pop_c})
                2'b10:   rx_level <= rx_level + RX_LW'(1);
                2'b01:   rx_level <= rx_level - RX_LW'(1);
                default: rx_level <= rx_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push_c) rx_mem[rx_wptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst || ctrl_wr_c) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovr_set_c)  overrun   <= 1'b1;
            if (ferr_set_c) frame_err <= 1'b1;
        end
    end

    // Status/data word
    assign rx_head_c = rx_empty_c ? 8'h00 : rx_mem[rx_rptr];
    assign csr_rdata = {tx_full_c, ~rx_empty_c, overrun, frame_err,
                        (~tx_empty_c | (tx_state != TX_IDLE)),
                        11'b0, 8'(rx_level), rx_head_c};

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Randomised scoreboard bench for uart_fifo_controller: serial TX decoder and
// RX frame driver checked against queue-based models of both FIFOs and flags.
module tb_uart_fifo_controller;
    localparam int F   = 8;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        txd;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wdata = 32'h0;
    logic        csr_re = 1'b0;
    logic [31:0] csr_rdata;
    logic [4:0]  tx_level;
    logic [4:0]  rx_level;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_model[$];
    bit          ovr_exp = 1'b0;
    bit          ferr_exp = 1'b0;
    bit          tx_check_en = 1'b1;
    bit          burst_mode = 1'b0;
    bit          prev_valid = 1'b0;
    int unsigned prev_start = 0;

    uart_fifo_controller #(
        .FREQ_DIV(F),
        .TX_DEPTH(TXD),
        .RX_DEPTH(RXD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .txd      (txd),
        .csr_we   (csr_we),
        .csr_wdata(csr_wdata),
        .csr_re   (csr_re),
        .csr_rdata(csr_rdata),
        .tx_level (tx_level),
        .rx_level (rx_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare RX-side status fields against the model (TX fields masked)
    task automatic check_rx(input string name);
        logic [31:0] e;
        e       = 32'h0;
        e[30]   = (rx_model.size() != 0);
        e[29]   = ovr_exp;
        e[28]   = ferr_exp;
        e[15:8] = 8'(rx_model.size());
        e[7:0]  = (rx_model.size() != 0) ? rx_model[0] : 8'h00;
        check(name, csr_rdata & 32'h77FF_FFFF, e);
        check({name, "_level"}, 32'(rx_level), 32'(rx_model.size()));
    endtask

    task automatic csr_write(input logic [31:0] d);
        @(negedge clk);
        csr_we    = 1'b1;
        csr_wdata = d;
        @(negedge clk);
        csr_we    = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (F) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (F) @(negedge clk);
        end
        rxd = stop;
        repeat (F) @(negedge clk);
        rxd = 1'b1;
        repeat (F) @(negedge clk);
        if (!stop) ferr_exp = 1'b1;
        else if (rx_model.size() < RXD) rx_model.push_back(b);
        else ovr_exp = 1'b1;
    endtask

    task automatic pop_rx(input string name);
        @(negedge clk);
        check(name, 32'(csr_rdata[7:0]), (rx_model.size() != 0) ? 32'(rx_model[0]) : 32'h0);
        csr_re = 1'b1;
        @(negedge clk);
        csr_re = 1'b0;
        if (rx_model.size() != 0) void'(rx_model.pop_front());
    endtask

    task automatic wait_tx_drain(input string name);
        int t;
        t = 0;
        while (tx_exp.size() != 0 && t < 40 * 10 * F) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(tx_exp.size()), 32'h0);
        repeat (F) @(negedge clk);
        check({name, "_busy"}, 32'(csr_rdata[27]), 32'h0);
        check({name, "_level"}, 32'(tx_level), 32'h0);
    endtask

    // Serial TX monitor: decodes frames on txd and pops the expected queue
    initial begin : tx_monitor
        logic [7:0]  b;
        int unsigned st;
        bit          stop_ok;
        b = 8'h0;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                st = cyc;
                repeat (F / 2) @(negedge clk);
                if (txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (F) @(negedge clk);
                        b[i] = txd;
                    end
                    repeat (F) @(negedge clk);
                    stop_ok = (txd === 1'b1);
                    if (tx_check_en) begin
                        check("tx_stop_bit", 32'(stop_ok), 32'h1);
                        if (tx_exp.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL tx_unexpected_byte: got 0x%02h expected none", b);
                        end else begin
                            check("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
                        end
                        if (burst_mode && prev_valid) check("tx_gap", st - prev_start, 32'(10 * F));
                        prev_start = st;
                        prev_valid = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        logic [7:0] rb;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdata", csr_rdata, 32'h0);
        check("reset_txd", 32'(txd), 32'h1);
        check("reset_tx_level", 32'(tx_level), 32'h0);
        check("reset_rx_level", 32'(rx_level), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // TX: latency, fill while a frame is in flight, drop on full
        burst_mode = 1'b1;
        prev_valid = 1'b0;
        tx_exp.push_back(8'hEE);
        csr_write(32'h0000_00EE);
        check("tx_lat_level", 32'(tx_level), 32'h1);
        check("tx_lat_idle", 32'(txd), 32'h1);
        check("tx_busy_rise", 32'(csr_rdata[27]), 32'h1);
        @(negedge clk);
        check("tx_lat_start", 32'(txd), 32'h0);
        check("tx_pop_level", 32'(tx_level), 32'h0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            csr_we    = 1'b1;
            csr_wdata = 32'(i);
            tx_exp.push_back(8'(i));
            @(negedge clk);
        end
        check("tx_full_flag", 32'(csr_rdata[31]), 32'h1);
        check("tx_full_level", 32'(tx_level), 32'(TXD));
        csr_wdata = 32'h0000_0055;
        @(negedge clk);
        csr_we = 1'b0;
        check("tx_drop_level", 32'(tx_level), 32'(TXD));
        wait_tx_drain("tx_burst_drain");
        burst_mode = 1'b0;

        // RX: fill, overrun, ordered drain
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 15) check_rx("rx_fill16");
            if (i == 16) check_rx("rx_overrun");
        end
        check_rx("rx_after_256");
        for (int i = 0; i < 16; i++) pop_rx("rx_pop_order");
        check_rx("rx_drained");

        // Frame error, then control flush
        send_frame(8'h11, 1'b1);
        check_rx("rx_good_before_ferr");
        send_frame(8'h3C, 1'b0);
        check_rx("rx_frame_error");
        csr_write(32'h8000_0000);
        rx_model.delete();
        ovr_exp  = 1'b0;
        ferr_exp = 1'b0;
        check_rx("rx_flush");

        // Short glitch is rejected, next frame still decodes
        @(negedge clk);
        rxd = 1'b0;
        repeat (F / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * F) @(negedge clk);
        check_rx("rx_false_start");
        send_frame(8'hA5, 1'b1);
        check_rx("rx_a5");
        pop_rx("rx_a5_pop");

        // Randomised mix of frames, pops, TX writes and flushes
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0, 1: send_frame(8'($urandom), ($urandom_range(0, 7) != 0));
                2: pop_rx("rnd_pop");
                3: begin
                    if (tx_exp.size() < TXD) begin
                        rb = 8'($urandom);
                        tx_exp.push_back(rb);
                        csr_write({24'h0, rb});
                    end
                end
                default: begin
                    @(negedge clk);
                    csr_we    = 1'b1;
                    csr_wdata = 32'h8000_0000 | 32'($urandom_range(0, 32'h7FFF_FFFF));
                    csr_re    = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    csr_we = 1'b0;
                    csr_re = 1'b0;
                    rx_model.delete();
                    ovr_exp  = 1'b0;
                    ferr_exp = 1'b0;
                end
            endcase
            check_rx("rnd_status");
        end
        wait_tx_drain("rnd_tx_drain");

        // Reset in the middle of a TX data bit
        tx_check_en = 1'b0;
        csr_write(32'h0000_005A);
        csr_write(32'h0000_00C3);
        repeat (F + F / 2) @(negedge clk);
        check("tx_pre_reset_level", 32'(tx_level), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", 32'(txd), 32'h1);
        check("rst_mid_tx_level", 32'(tx_level), 32'h0);
        check("rst_mid_rdata", csr_rdata, 32'h0);
        rx_model.delete();
        ovr_exp  = 1'b0;
        ferr_exp = 1'b0;
        rst = 1'b0;
        repeat (12 * F) @(negedge clk);
        tx_check_en = 1'b1;
        prev_valid  = 1'b0;
        repeat (12 * F) @(negedge clk);
        check("post_reset_txd", 32'(txd), 32'h1);
        check_rx("post_reset_rx");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_fifo_controller.md
# uart_fifo_controller

Parametrised, buffered successor to the single-byte UART controller behind the `CSR_UARTFIFO` CSR. It has:
- independent TX and RX FIFOs of configurable depth;
- double-synchronised RX sampling with mid-bit sampling, false-start rejection and frame-error detection;
- sticky overrun and frame-error flags.

It sits between the csrfile (one 32-bit read/write CSR port) and the board UART pins. Frame format is fixed 8N1, LSB first.

## Interface
Parameters:
- FREQ_DIV, default 868: clock cycles per UART bit. Must be ≥ 4.
- TX_DEPTH, default 16: TX FIFO entries. Power of two, 2..128.
- RX_DEPTH, default 16: RX FIFO entries. Power of two, 2..128.

Ports:
- clk  in  1  system clock. Everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  serial input. Asynchronous; idle high.
- txd  out  1  serial output. Registered; idle high.
- csr_we  in  1  CSR write strobe.
- csr_wdata  in  32  CSR write data.
- csr_re  in  1  RX pop strobe: the commit stage has consumed csr_rdata[7:0].
- csr_rdata  out  32  status/data word, combinational from registers only.
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.

## Operation
csr_rdata fields:
- [31] TX FIFO full.
- [30] RX FIFO non-empty.
- [29] sticky RX overrun.
- [28] sticky frame error.
- [27] TX busy: TX FIFO non-empty or TX FSM not in IDLE.
- [26:16] zero.
- [15:8] rx_level, zero-extended.
- [7:0] RX FIFO head. Reads 0 when the RX FIFO is empty.

CSR write:
- csr_wdata[31]=1: control write. Flushes the RX FIFO and clears [29] and [28]. Bits [30:0] are ignored.
- csr_wdata[31]=0: pushes csr_wdata[7:0] into the TX FIFO.
- A push is accepted if the TX FIFO is not full, or if the TX FSM pops in the same cycle. Otherwise the byte is silently dropped.

RX pop:
- csr_re with the RX FIFO non-empty pops the head.
- csr_re with the RX FIFO empty is a no-op.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: when the FIFO is non-empty, pop it into the shift register, drive txd=0 and go to START.
- START, DATA and STOP each last FREQ_DIV cycles per bit, counted by a bit-period counter.
- DATA sends 8 bits, LSB first.
- STOP drives txd=1 for FREQ_DIV cycles, then returns to IDLE.
- Back-to-back bytes have no extra idle cycle. IDLE pops on the same edge it is entered if the FIFO is non-empty.

RX FSM (IDLE, START, DATA, STOP):
- rxd passes through a 2-flop synchroniser; the FSM sees rxs.
- IDLE: rxs=0 enters START and loads the counter with FREQ_DIV/2.
- START: at the mid-start sample, rxs=1 is a false start and returns to IDLE. rxs=0 enters DATA.
- DATA: samples 8 bits, each FREQ_DIV cycles after the previous sample.
- STOP: samples once, FREQ_DIV cycles after the last data bit.
  - stop=1 and FIFO not full, or a pop in the same cycle: push the byte.
  - stop=1 and FIFO full with no pop: drop the byte and set overrun.
  - stop=0: drop the byte and set frame error.
- The FSM returns to IDLE right after the stop sample.

Simultaneous events:
- Push and pop in the same cycle on either FIFO: both take effect and the level is unchanged.
- Control flush and an RX push in the same cycle: the flush wins and the byte is discarded. A flag set event in the same cycle as a clear also loses to the clear.
- Control write and csr_re in the same cycle: the flush wins.

## Timing
- Reset values: txd=1, both FIFOs empty, tx_level=0, rx_level=0, flags=0, both FSMs in IDLE, synchroniser flops=1. Hence csr_rdata=0.
- rst asserted mid-frame aborts both FSMs. txd=1 from the next edge.
- TX latency: a push at edge E makes txd=0 after edge E+1 (the pop edge). The frame then occupies 10·FREQ_DIV cycles.
- csr_rdata[27] rises after E, and falls the cycle after STOP completes with the TX FIFO empty.
- RX latency: the stop sample is taken 2 + FREQ_DIV/2 + 9·FREQ_DIV cycles after the rxd falling edge. The byte and [30] are visible the cycle after that sample.
- csr_re at edge E: the new head and rx_level are visible after E.
- Level counters are exact. FIFO pointers wrap modulo depth.
- Full: level == DEPTH, not a pointer comparison alone.

## Test plan
- Reset, then read: csr_rdata=0, txd=1, tx_level=0, rx_level=0.
- Write bytes 0x00..0x0F back-to-back (TX_DEPTH=16):
  - bench receiver decodes 0x00..0x0F in order, with no gap between stop and next start;
  - [31]=1 after the 16th write while the FSM has not yet popped;
  - a 17th write in the same state is dropped.
- Drive frames 0x00..0xFF on rxd without popping (RX_DEPTH=16):
  - the first 16 bytes are stored in order, rx_level=16;
  - [29]=1 after the 17th frame;
  - popping returns 0x00..0x0F.
- Drive a frame with stop bit 0: [28]=1, rx_level unchanged. Then write 0x80000000: csr_rdata[30:28]=0, rx_level=0.
- Drive a 0-pulse of FREQ_DIV/4 cycles on rxd: no byte is stored and the RX FSM is back in IDLE. A following valid 0xA5 frame is received correctly.
- Assert rst during the DATA bit of a TX frame: txd=1 next cycle, tx_level=0, csr_rdata[27]=0.
